prog_loader: RTL and testbench
==============================

# prog_loader

Program loader and instruction store for the MCX core. Receives a framed program image over a byte-wide valid/ready stream, writes it into a 16-entry × 46-bit instruction memory, and serves the core's instruction fetch port (`addr` → `line`). It holds the core in reset while a load is in progress and releases it only after a frame commits cleanly. It also supplies the program-length wrap index the core needs to return to line 0.

## Interface
- No parameters; geometry is fixed: 16 lines, 46-bit line, 8-bit input stream.
- `clk  in  1` — clock.
- `nrst  in  1` — reset, asynchronous, active-low.
- `in_data  in  8` — stream byte.
- `in_valid  in  1` — `in_data` is valid this cycle.
- `in_ready  out  1` — loader accepts a byte this cycle; a byte transfers when `in_valid && in_ready` at posedge `clk`.
- `addr  in  4` — core fetch address.
- `line  out  46` — memory contents at `addr`; combinational read.
- `prog_last  out  4` — index of the last valid line (N−1); the core wraps from this value to 0.
- `core_run  out  1` — 1 = core may run; drives the core's reset release.
- `err  out  1` — last frame was rejected; sticky until the next header byte.

## Operation
- Frame format, in stream order:
  - header `0xA5`;
  - count byte N, legal range 1..16;
  - N lines × 6 bytes, big-endian; byte 0 is bits 47:40, and bits 47:46 are discarded;
  - checksum byte: XOR of the count byte and all line bytes.
- States: IDLE, COUNT, DATA, CSUM, RUN, ERROR.
- IDLE: byte `0xA5` → COUNT, clear `err`; any other byte is discarded.
- COUNT: if N is 0 or >16 → ERROR. Otherwise latch `cnt = N`, clear line index and byte index, seed checksum with N → DATA.
- DATA: shift each byte into a 48-bit assembly register and XOR it into the checksum.
  - On the 6th byte of a line, write bits 45:0 to `mem[line_idx]`, increment `line_idx`, reset the byte index.
  - After line N−1 is written → CSUM.
- CSUM: byte equals the running checksum → RUN, `prog_last <= cnt−1`. Mismatch → ERROR.
- RUN: `core_run = 1`. Byte `0xA5` → COUNT (load restarts, `core_run` drops). Other bytes are discarded.
- ERROR: `err = 1`, `core_run = 0`. Byte `0xA5` → COUNT, clear `err`. Other bytes are discarded.
- `core_run` is 1 only in RUN.
- Lines ≥ N keep their prior contents. The core never fetches them because it wraps at `prog_last`.
- A failed or aborted frame leaves memory partially overwritten. The core stays held until a good frame commits.

## Timing
- Reset values:
  - state IDLE, `core_run = 0`, `err = 0`, `prog_last = 4'd0`, `in_ready = 0` while `nrst` is low;
  - all 16 `mem` entries = 46'd0;
  - `line = mem[addr]`, which is 0.
- `in_ready = 1` in every state once out of reset: one byte per cycle, no backpressure.
- Memory write: the entry updates at the posedge that accepts the line's 6th byte. `line` reflects the new value from the next cycle.
- `core_run` rises at the posedge that accepts a matching checksum byte. The first core fetch is at `addr = 0` on the following cycle.
- `core_run` falls at the posedge that accepts `0xA5` in RUN.
- `prog_last` is registered only on commit; it is unchanged during load and on error.
- Bubbles (`in_valid = 0`) between bytes have no effect; there is no timeout.
- Reset mid-frame aborts to IDLE and clears memory.
- `0xA5` inside DATA or CSUM is treated as data, not as a header.

## Configuration
- `PROG_LOADER_CHECKSUM_EN`
  - Defined: CSUM state and checksum check exist as described.
  - Undefined: no checksum byte and no checksum logic. DATA → RUN directly on the last line's 6th byte, with `prog_last` set at that same edge. `err` asserts only for an illegal count.

## Test plan
- Reset: assert `nrst` low mid-cycle → `core_run = 0`, `err = 0`, `prog_last = 0`, `line = 0` at every `addr` (asynchronous).
- Single-line frame `A5 01 00 01 02 03 04 05 00` → `core_run` high the cycle after the last byte; `prog_last = 0`; `addr = 0` gives `line = 46'h0102030405`.
- 16-line frame with correct checksum → `prog_last = 15`; all 16 lines read back exactly. Insert random `in_valid` bubbles; the result must be identical.
- Bad checksum (same frame as the single-line case, last byte `0x01`) → `err = 1`, `core_run = 0`. A subsequent good frame → `err` clears on its header and `core_run = 1`.
- Illegal count `A5 00` and `A5 11` → ERROR after the count byte. Following bytes other than `0xA5` are ignored.
- Reload while running: `0xA5` in RUN → `core_run` drops the next cycle. A new 3-line frame → `prog_last = 2`, lines 3..15 unchanged.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader and 16 x 46-bit instruction store for the MCX core.
// Optional checksum byte and check: define PROG_LOADER_CHECKSUM_EN.
module prog_loader (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  addr,
    output logic [45:0] line,
    output logic [3:0]  prog_last,
    output logic        core_run,
    output logic        err
);

    // state | meaning
    // IDLE  | waiting for header 0xA5
    // COUNT | next byte is the line count N
    // DATA  | receiving N lines of 6 bytes
    // CSUM  | next byte is the checksum (checksum builds only)
    // RUN   | program committed, core released
    // ERROR | frame rejected, core held, err set
    typedef enum logic [2:0] {IDLE, COUNT, DATA, CSUM, RUN, ERROR} state_t;

    state_t      state;
    logic [3:0]  last_idx;
    logic [3:0]  line_idx;
    logic [2:0]  byte_idx;
    logic [39:0] shreg;
    logic [45:0] mem [16];
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic accept;
    assign accept = in_valid && in_ready;
    assign line   = mem[addr];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            core_run  <= 1'b0;
            err       <= 1'b0;
            prog_last <= 4'd0;
            last_idx  <= 4'd0;
            line_idx  <= 4'd0;
            byte_idx  <= 3'd0;
            shreg     <= 40'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
            for (int i = 0; i < 16; i++) mem[i] <= 46'd0;
        end else begin
            in_ready <= 1'b1;
            if (accept) begin
                case (state)
                    IDLE, RUN, ERROR: begin
                        if (in_data == 8'hA5) begin
                            state    <= COUNT;
                            err      <= 1'b0;
                            core_run <= 1'b0;
                        end
                    end
                    COUNT: begin
                        if (in_data == 8'd0 || in_data > 8'd16) begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end else begin
                            // N=16 wraps to 0 in the low nibble, so N-1 lands on 15
                            last_idx <= in_data[3:0] - 4'd1;
                            line_idx <= 4'd0;
                            byte_idx <= 3'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum     <= in_data;
`endif
                            state    <= DATA;
                        end
                    end
                    DATA: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum <= csum ^ in_data;
`endif
                        if (byte_idx == 3'd5) begin
                            // shreg[39:38] hold line bits 47:46, which are dropped
                            mem[line_idx] <= {shreg[37:0], in_data};
                            line_idx      <= line_idx + 4'd1;
                            byte_idx      <= 3'd0;
                            if (line_idx == last_idx) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                                state <= CSUM;
`else
                                state     <= RUN;
                                prog_last <= last_idx;
                                core_run  <= 1'b1;
`endif
                            end
                        end else begin
                            shreg    <= {shreg[31:0], in_data};
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    CSUM: begin
                        if (in_data == csum) begin
                            state     <= RUN;
                            prog_last <= last_idx;
                            core_run  <= 1'b1;
                        end else begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus queues expected observations,
// a monitor process drives addr, samples the outputs and compares.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  addr = 4'd0;
    logic [45:0] line;
    logic [3:0]  prog_last;
    logic        core_run;
    logic        err;

    prog_loader dut (
        .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .addr(addr), .line(line), .prog_last(prog_last),
        .core_run(core_run), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 line, 1 core_run, 2 err, 3 prog_last, 4 in_ready
        logic [3:0]  a;
        logic [45:0] exp;
    } chk_t;

    chk_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;

    logic [45:0] exp_mem [16];
    logic [3:0]  exp_last;
    logic        exp_run;
    logic        exp_err;
    logic [47:0] frame_lines [16];

    always @(negedge clk) begin
        if (q.size() > 0) begin
            chk_t c;
            logic [45:0] act;
            string nm;
            c = q.pop_front();
            addr = c.a;
            #1;
            case (c.kind)
                0:       begin act = line;               nm = "line";      end
                1:       begin act = {45'd0, core_run};  nm = "core_run";  end
                2:       begin act = {45'd0, err};       nm = "err";       end
                3:       begin act = {42'd0, prog_last}; nm = "prog_last"; end
                default: begin act = {45'd0, in_ready};  nm = "in_ready";  end
            endcase
            vectors++;
            if (act !== c.exp) begin
                miscompares++;
                $display("FAIL %s addr=%0d got=%h expected=%h t=%0t", nm, c.a, act, c.exp, $time);
            end
        end
    end

    task automatic push(input int kind, input logic [3:0] a, input logic [45:0] e);
        chk_t c;
        c.kind = kind; c.a = a; c.exp = e;
        q.push_back(c);
    endtask

    task automatic push_status();
        push(1, 4'd0, {45'd0, exp_run});
        push(2, 4'd0, {45'd0, exp_err});
        push(3, 4'd0, {42'd0, exp_last});
    endtask

    task automatic push_all();
        push_status();
        for (int i = 0; i < 16; i++) push(0, 4'(i), exp_mem[i]);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout pending=%0d required=0", q.size());
            q.delete();
        end
        @(negedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bub);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout got=0 required=1");
        end
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (bub) repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    // Sends header, checks the hold, then count, lines and (optionally) checksum.
    task automatic send_frame(input int n, input bit bub, input bit bad);
        logic [7:0] cs;
        logic [47:0] w;
        send_byte(8'hA5, bub);
        exp_run = 1'b0;
        exp_err = 1'b0;
        push_status();
        drain();
        cs = 8'(n);
        send_byte(8'(n), bub);
        for (int i = 0; i < n; i++) begin
            w = frame_lines[i];
            for (int k = 5; k >= 0; k--) begin
                cs = cs ^ w[k*8 +: 8];
                send_byte(w[k*8 +: 8], bub);
            end
            exp_mem[i] = w[45:0];
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(bad ? (cs ^ 8'h01) : cs, bub);
`endif
        if (bad) begin
            exp_err = 1'b1;
            exp_run = 1'b0;
        end else begin
            exp_run  = 1'b1;
            exp_last = 4'(n - 1);
        end
        push_all();
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) exp_mem[i] = 46'd0;
        exp_last = 4'd0; exp_run = 1'b0; exp_err = 1'b0;

        // power-on reset state, observed while nrst is held low
        #3;
        push(4, 4'd0, 46'd0);
        push_all();
        drain();
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        push(4, 4'd0, 46'd1);
        drain();

        // single line: A5 01 00 01 02 03 04 05 (00)
        frame_lines[0] = 48'h000102030405;
        send_frame(1, 1'b0, 1'b0);
        push(0, 4'd0, 46'h0102030405);
        drain();

`ifdef PROG_LOADER_CHECKSUM_EN
        // bad checksum, then a good frame clears err on its header
        send_frame(1, 1'b0, 1'b1);
        send_frame(1, 1'b0, 1'b0);
`endif

        // full 16-line image, with 0xA5 inside the data and bits 47:46 set
        for (int i = 0; i < 16; i++)
            frame_lines[i] = {8'hC3 ^ 8'(i), 8'h5A, 8'hA5, 8'(i * 17), 8'h0F, 8'(255 - i)};
        send_frame(16, 1'b0, 1'b0);
        // same image again with random bubbles on in_valid
        send_frame(16, 1'b1, 1'b0);

        // illegal counts; non-header bytes after them are ignored
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        exp_run = 1'b0; exp_err = 1'b1;
        push_status();
        drain();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        push_all();
        drain();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0);
        push_all();
        drain();

        // good frame to reach RUN, then reload with a 3-line program
        send_frame(16, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            frame_lines[i] = {8'h7F, 8'(i), 8'hA5, 8'hA5, 8'h3C, 8'(i + 1)};
        send_frame(3, 1'b1, 1'b0);

        // async reset asserted mid-cycle clears everything
        @(posedge clk);
        #3;
        nrst = 1'b0;
        #1;
        vectors++;
        if (core_run !== 1'b0 || err !== 1'b0 || prog_last !== 4'd0 || line !== 46'd0) begin
            miscompares++;
            $display("FAIL async_reset got run=%b err=%b last=%h line=%h required 0", core_run, err, prog_last, line);
        end
        for (int i = 0; i < 16; i++) exp_mem[i] = 46'd0;
        exp_last = 4'd0; exp_run = 1'b0; exp_err = 1'b0;
        push(4, 4'd0, 46'd0);
        push_all();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
